fp_seq_normalizer: RTL and testbench

Sequential, parametrised normaliser and rounder for the floating-point divider datapath. It accepts the raw double-width quotient and biased exponent, aligns the quotient over one or more cycles, and applies round-to-nearest-even with overflow and underflow handling. It emits a packed hidden-bit mantissa and a final exponent behind a valid/ready handshake. It sits between the mantissa divider and the result packer, and replaces the single-cycle, truncating normalisation step.

---
 rtl/fp_seq_normalizer.sv | 164 ++++++++++++++++
 tb/tb_fp_seq_normalizer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_seq_normalizer.sv
// Multi-cycle normaliser/rounder for the divider quotient: aligns the raw quotient,
// then applies round-to-nearest-even with overflow/underflow flush, behind valid/ready.
module fp_seq_normalizer #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int SHIFT_STEP     = 1
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      valid_in,
    output logic                                      ready_out,
    input  logic [EXP_WIDTH-1:0]                      expoent_in,
    input  logic [2*(MANTISSA_WIDTH+1)+2-1:0]         result_in,
    output logic                                      valid_out,
    input  logic                                      ready_in,
    output logic [EXP_WIDTH-1:0]                      normal_e_out,
    output logic [MANTISSA_WIDTH:0]                   normal_m_out,
    output logic                                      overflow_out,
    output logic                                      underflow_out,
    output logic                                      inexact_out,
    output logic [1:0]                                state_dbg_out
);
    localparam int RW = 2*(MANTISSA_WIDTH+1)+2;
    localparam int EW = EXP_WIDTH+2;
    localparam int MW = MANTISSA_WIDTH;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_WIDTH) - 1);

    // Handshake: an operand transfers on a rising edge with valid_in && ready_out;
    // a result transfers on a rising edge with valid_out && ready_in. Both sides hold until then.
    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          w_q, w_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   s_q, s_d;
    logic [EXP_WIDTH-1:0]   ne_q, ne_d;
    logic [MW:0]            nm_q, nm_d;
    logic                   ov_q, ov_d, un_q, un_d, ix_q, ix_d;

    logic [MW:0]            kept;
    logic                   guard, sticky, round_up, carry;
    logic [MW+1:0]          sum;
    logic [MW:0]            mant_r;
    logic signed [EW-1:0]   e_r;
    int                     lz, sh;

    function automatic int lz_count(input logic [RW-1:0] w);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        for (int i = RW-2; i >= 0; i--) begin
            if (!found) begin
                if (w[i]) found = 1'b1;
                else      n = n + 1;
            end
        end
        return n;
    endfunction

    always_comb begin
        lz       = lz_count(w_q);
        sh       = (lz < SHIFT_STEP) ? lz : SHIFT_STEP;
        kept     = w_q[RW-2 -: MW+1];
        guard    = w_q[RW-3-MW];
        sticky   = (|w_q[RW-4-MW:0]) | s_q;
        round_up = guard & (sticky | kept[0]);
        sum      = {1'b0, kept} + {{(MW+1){1'b0}}, round_up};
        carry    = sum[MW+1];
        // A carry out means the rounded value is exactly 2.0, i.e. 1.000..0 one binade up.
        mant_r   = carry ? {1'b1, {MW{1'b0}}} : sum[MW:0];
        e_r      = carry ? e_q + EW'(1) : e_q;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        e_d     = e_q;
        s_d     = s_q;
        ne_d    = ne_q;
        nm_d    = nm_q;
        ov_d    = ov_q;
        un_d    = un_q;
        ix_d    = ix_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    w_d     = result_in;
                    e_d     = $signed({2'b00, expoent_in});
                    s_d     = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (w_q == '0) begin
                    state_d = ROUND;
                end else if (w_q[RW-1]) begin
                    w_d     = {1'b0, w_q[RW-1:1]};
                    s_d     = s_q | w_q[0];
                    e_d     = e_q + EW'(1);
                    state_d = ROUND;
                end else if (w_q[RW-2]) begin
                    state_d = ROUND;
                end else begin
                    w_d = w_q << sh;
                    e_d = e_q - EW'(sh);
                end
            end
            ROUND: begin
                state_d = DONE;
                if (w_q == '0) begin
                    ne_d = '0; nm_d = '0; ov_d = 1'b0; un_d = 1'b0; ix_d = 1'b0;
                end else if (e_r[EW-1] || (e_r == '0)) begin
                    ne_d = '0; nm_d = '0; ov_d = 1'b0; un_d = 1'b1; ix_d = 1'b1;
                end else if (e_r >= E_MAX) begin
                    ne_d = '1; nm_d = '0; ov_d = 1'b1; un_d = 1'b0; ix_d = 1'b1;
                end else begin
                    ne_d = e_r[EXP_WIDTH-1:0];
                    nm_d = mant_r;
                    ov_d = 1'b0;
                    un_d = 1'b0;
                    ix_d = guard | sticky;
                end
            end
            DONE: begin
                if (ready_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            w_q     <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            ne_q    <= '0;
            nm_q    <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            ix_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            e_q     <= e_d;
            s_q     <= s_d;
            ne_q    <= ne_d;
            nm_q    <= nm_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            ix_q    <= ix_d;
        end
    end

    assign ready_out     = (state_q == IDLE);
    assign valid_out     = (state_q == DONE);
    assign normal_e_out  = ne_q;
    assign normal_m_out  = nm_q;
    assign overflow_out  = ov_q;
    assign underflow_out = un_q;
    assign inexact_out   = ix_q;
    assign state_dbg_out = state_q;
endmodule

// File: tb/tb_fp_seq_normalizer.sv
// Bench for fp_seq_normalizer: two instances (SHIFT_STEP 1 and 4), directed vectors,
// queue scoreboard checked by a negedge monitor.
module tb_fp_seq_normalizer;
  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic [2:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        vin[2];
  logic        rdy_in[2];
  logic [7:0]  exp_in[2];
  logic [49:0] res_in[2];
  logic        rdy_out[2];
  logic        vout[2];
  logic [7:0]  ne[2];
  logic [23:0] nm[2];
  logic        ov[2];
  logic        un[2];
  logic        ix[2];
  logic [1:0]  dbg[2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic        vprev[2];
  logic [7:0]  se[2];
  logic [23:0] sm[2];
  logic [2:0]  sf[2];
  int          rise[2];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  fp_seq_normalizer #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .SHIFT_STEP(1)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(vin[0]), .ready_out(rdy_out[0]),
    .expoent_in(exp_in[0]), .result_in(res_in[0]), .valid_out(vout[0]), .ready_in(rdy_in[0]),
    .normal_e_out(ne[0]), .normal_m_out(nm[0]), .overflow_out(ov[0]),
    .underflow_out(un[0]), .inexact_out(ix[0]), .state_dbg_out(dbg[0])
  );

  fp_seq_normalizer #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .SHIFT_STEP(4)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(vin[1]), .ready_out(rdy_out[1]),
    .expoent_in(exp_in[1]), .result_in(res_in[1]), .valid_out(vout[1]), .ready_in(rdy_in[1]),
    .normal_e_out(ne[1]), .normal_m_out(nm[1]), .overflow_out(ov[1]),
    .underflow_out(un[1]), .inexact_out(ix[1]), .state_dbg_out(dbg[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_step(input int d);
    exp_t x;
    if (vout[d]) begin
      if (!vprev[d]) begin
        rise[d] = cyc;
        se[d] = ne[d];
        sm[d] = nm[d];
        sf[d] = {ov[d], un[d], ix[d]};
      end else begin
        chk($sformatf("hold_e%0d", d), 64'(ne[d]), 64'(se[d]));
        chk($sformatf("hold_m%0d", d), 64'(nm[d]), 64'(sm[d]));
        chk($sformatf("hold_flags%0d", d), 64'({ov[d], un[d], ix[d]}), 64'(sf[d]));
        chk($sformatf("busy_ready%0d", d), 64'(rdy_out[d]), 64'(0));
      end
      if (rdy_in[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_valid%0d", d), 64'(vout[d]), 64'(0));
        end else begin
          if (d == 0) x = q0.pop_front();
          else        x = q1.pop_front();
          chk($sformatf("exp%0d", d), 64'(ne[d]), 64'(x.e));
          chk($sformatf("mant%0d", d), 64'(nm[d]), 64'(x.m));
          chk($sformatf("flags%0d", d), 64'({ov[d], un[d], ix[d]}), 64'(x.fl));
          chk($sformatf("latency%0d", d), 64'(rise[d] - x.acc), 64'(x.lat));
        end
      end
    end
    vprev[d] = vout[d];
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      vprev[0] = 1'b0;
      vprev[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  // flags argument is {overflow, underflow, inexact}
  task automatic send(input int d, input logic [49:0] r, input logic [7:0] x,
                      input logic [7:0] ee, input logic [23:0] mm, input logic [2:0] fl,
                      input int lat, input bit push = 1'b1);
    exp_t t;
    int waited = 0;
    @(negedge clk_in);
    vin[d] = 1'b1;
    res_in[d] = r;
    exp_in[d] = x;
    while (!rdy_out[d] && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    if (!rdy_out[d]) begin
      chk("accept_timeout", 64'(rdy_out[d]), 64'(1));
    end else if (push) begin
      t.e = ee; t.m = mm; t.fl = fl; t.lat = lat; t.acc = cyc + 1;
      if (d == 0) q0.push_back(t);
      else        q1.push_back(t);
    end
    @(posedge clk_in);
    #1 vin[d] = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 500) begin
      @(negedge clk_in);
      waited++;
    end
    chk("drain_timeout", 64'(q0.size() + q1.size()), 64'(0));
  endtask

  initial begin
    rst_in = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vin[d] = 1'b0; rdy_in[d] = 1'b1; exp_in[d] = '0; res_in[d] = '0;
      vprev[d] = 1'b0; rise[d] = 0; se[d] = '0; sm[d] = '0; sf[d] = '0;
    end
    repeat (3) @(negedge clk_in);
    chk("rst_ready", 64'(rdy_out[0]), 64'(1));
    chk("rst_valid", 64'(vout[0]), 64'(0));
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_outs%0d", d),
          64'({vout[d], ne[d], nm[d], ov[d], un[d], ix[d]}), 64'(0));
      chk($sformatf("rst_ready%0d", d), 64'(rdy_out[d]), 64'(1));
    end

    send(0, 50'd1 << 48, 8'd127, 8'd127, 24'h800000, 3'b000, 2);
    send(0, 50'd1 << 45, 8'd127, 8'd124, 24'h800000, 3'b000, 5);
    send(0, (50'd1 << 49) | (50'd1 << 25), 8'd127, 8'd128, 24'h800000, 3'b001, 2);
    send(0, (50'd1 << 49) | (50'd1 << 26) | (50'd1 << 25), 8'd127, 8'd128, 24'h800002, 3'b001, 2);
    send(0, (50'd1 << 49) - (50'd1 << 24), 8'd254, 8'hFF, 24'h000000, 3'b101, 2);
    send(0, 50'd1 << 40, 8'd5, 8'd0, 24'h000000, 3'b011, 10);
    send(0, 50'd0, 8'd100, 8'd0, 24'h000000, 3'b000, 2);
    send(0, (50'd1 << 48) | (50'd1 << 24) | 50'd1, 8'd127, 8'd127, 24'h800001, 3'b001, 2);
    send(0, (50'd1 << 49) | (50'd1 << 25) | 50'd1, 8'd127, 8'd128, 24'h800001, 3'b001, 2);
    send(0, 50'd1 << 48, 8'd254, 8'd254, 24'h800000, 3'b000, 2);
    send(0, 50'd1 << 48, 8'd255, 8'hFF, 24'h000000, 3'b101, 2);
    send(0, 50'd1 << 47, 8'd2, 8'd1, 24'h800000, 3'b000, 3);
    send(0, 50'd1 << 47, 8'd1, 8'd0, 24'h000000, 3'b011, 3);

    send(1, 50'd1 << 45, 8'd127, 8'd124, 24'h800000, 3'b000, 3);
    send(1, 50'd1 << 42, 8'd127, 8'd121, 24'h800000, 3'b000, 4);
    send(1, 50'd1 << 40, 8'd5, 8'd0, 24'h000000, 3'b011, 4);
    send(1, 50'd1 << 48, 8'd127, 8'd127, 24'h800000, 3'b000, 2);
    drain();

    // Back-pressure: hold the result for 5 cycles while a new operand is offered.
    rdy_in[0] = 1'b0;
    send(0, (50'd1 << 48) | (50'd1 << 30), 8'd100, 8'd100, 24'h800020, 3'b000, 2);
    for (int i = 0; i < 20 && !vout[0]; i++) @(negedge clk_in);
    chk("bp_valid", 64'(vout[0]), 64'(1));
    vin[0] = 1'b1;
    res_in[0] = 50'd1 << 48;
    exp_in[0] = 8'd1;
    repeat (5) @(negedge clk_in);
    vin[0] = 1'b0;
    rdy_in[0] = 1'b1;
    drain();
    repeat (6) @(negedge clk_in);
    chk("busy_operand_ignored", 64'(vout[0]), 64'(0));

    // Reset in the middle of ALIGN discards the operation.
    send(0, 50'd1 << 40, 8'd5, 8'd0, 24'h0, 3'b011, 10, 1'b0);
    repeat (2) @(posedge clk_in);
    #2;
    chk("mid_state_align", 64'(dbg[0]), 64'(1));
    rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(vout[0]), 64'(0));
    chk("mid_rst_ready", 64'(rdy_out[0]), 64'(1));
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (12) @(negedge clk_in);
    chk("post_rst_no_valid", 64'(vout[0]), 64'(0));
    send(0, 50'd1 << 45, 8'd127, 8'd124, 24'h800000, 3'b000, 5);
    drain();
    repeat (3) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
